// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the multicycle CPU memory port.
// The controller issues single-cycle MemRead/MemWrite strobes. A word access
// is performed on an internal RAM after READ_LAT/WRITE_LAT cycles, and
// completion is signalled with a one-cycle ready pulse. Misaligned,
// out-of-range and conflicting (read+write) requests complete after one
// cycle with err=1 and never touch the RAM.
//
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   mem_read  read request strobe
//   mem_write write request strobe
//   addr      byte address (32 bits)
//   wdata     write data (32 bits)
//   rdata     read data; valid with ready after a read; held until the next good read
//   ready     one-cycle completion pulse
//   err       one-cycle error pulse, coincident with ready
//   busy      high while a request is in flight
module mem_responder #(
  parameter int ADDR_BITS = 10,
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int DATA_W  = 32;
  localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  // The counter only ever holds LAT-2, so $clog2(MAX_LAT) bits are enough.
  localparam int CNT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [DATA_W-1:0]    mem [0:(2**ADDR_BITS)-1];

  logic [1:0]           state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic                 op_wr_q, err_q;
  logic [ADDR_BITS-1:0] word_addr_q;
  logic [DATA_W-1:0]    wdata_q;

  logic                 req, req_err;
  int                   acc_lat;
  // Request attributes as seen this cycle: live inputs while IDLE, the
  // latched copies otherwise. Lets a LAT=1 read fetch data on the
  // acceptance edge itself.
  logic                 op_wr_cur, err_cur;
  logic [ADDR_BITS-1:0] word_addr_cur;

  always_comb begin
    req     = mem_read | mem_write;
    req_err = (mem_read & mem_write) | (addr[1:0] != 2'b00) |
              (addr[31:ADDR_BITS+2] != '0);
    acc_lat = mem_write ? WRITE_LAT : READ_LAT;

    if (state == S_IDLE) begin
      op_wr_cur     = mem_write;
      err_cur       = req_err;
      word_addr_cur = addr[ADDR_BITS+1:2];
    end else begin
      op_wr_cur     = op_wr_q;
      err_cur       = err_q;
      word_addr_cur = word_addr_q;
    end

    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (req) begin
          // Errors skip the wait states entirely.
          if (req_err || acc_lat == 1) begin
            state_nxt = S_RESP;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = CNT_W'(acc_lat - 2);
          end
        end
      end
      S_WAIT: begin
        if (cnt == '0) state_nxt = S_RESP;
        else           cnt_nxt   = cnt - 1'b1;
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      op_wr_q <= 1'b0;
      err_q   <= 1'b0;
      ready   <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
      rdata   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == S_IDLE && req) begin
        op_wr_q <= mem_write;
        err_q   <= req_err;
      end
      ready <= (state_nxt == S_RESP);
      err   <= (state_nxt == S_RESP) && err_cur;
      busy  <= (state_nxt != S_IDLE);
      // Load read data on the edge entering RESP so it is valid with ready.
      if (state_nxt == S_RESP && state != S_RESP && !op_wr_cur && !err_cur)
        rdata <= mem[word_addr_cur];
    end
  end

  // Request data capture at acceptance
  always_ff @(posedge clk) begin
    if (state == S_IDLE && req) begin
      word_addr_q <= addr[ADDR_BITS+1:2];
      wdata_q     <= wdata;
    end
  end

  // RAM commit on the edge ending RESP; a reset beforehand returns the FSM
  // to IDLE, so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (state == S_RESP && op_wr_q && !err_q)
      mem[word_addr_q] <= wdata_q;
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed self-checking bench for mem_responder.
// Instance dut uses READ_LAT=2/WRITE_LAT=1; dut3 uses WRITE_LAT=3 for the
// reset-during-wait scenario.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mr0 = 1'b0, mw0 = 1'b0, mr1 = 1'b0, mw1 = 1'b0;
  logic [31:0] ad0 = '0, wd0 = '0, ad1 = '0, wd1 = '0;
  logic [31:0] rd0, rd1;
  logic        rdy0, rdy1, er0, er1, bs0, bs1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_BITS(10), .READ_LAT(2), .WRITE_LAT(1)) dut (
    .clk(clk), .rst(rst), .mem_read(mr0), .mem_write(mw0), .addr(ad0),
    .wdata(wd0), .rdata(rd0), .ready(rdy0), .err(er0), .busy(bs0));

  mem_responder #(.ADDR_BITS(10), .READ_LAT(2), .WRITE_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .mem_read(mr1), .mem_write(mw1), .addr(ad1),
    .wdata(wd1), .rdata(rd1), .ready(rdy1), .err(er1), .busy(bs1));

  // Issue one request, drop the strobes after the acceptance edge and wait
  // (bounded) for ready. lat = negedges after acceptance until ready (0 if
  // it never came), bcyc = negedges with busy high.
  task automatic issue(input bit sel, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d,
                       output int lat, output logic e, output logic [31:0] q,
                       output int bcyc);
    @(negedge clk);
    if (sel) begin mr1 = r; mw1 = w; ad1 = a; wd1 = d; end
    else     begin mr0 = r; mw0 = w; ad0 = a; wd0 = d; end
    @(posedge clk);
    lat = 0; e = 1'b0; q = '0; bcyc = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin mr0 = 0; mw0 = 0; mr1 = 0; mw1 = 0; end
      if (sel ? bs1 : bs0) bcyc++;
      if (sel ? rdy1 : rdy0) begin
        lat = i;
        e   = sel ? er1 : er0;
        q   = sel ? rd1 : rd0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", rdy0); end
    checks++; if (er0 !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", er0); end
    checks++; if (bs0 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bs0); end
    checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rd0); end
    checks++; if (bs1 !== 1'b0 || rdy1 !== 1'b0) begin errors++; $display("FAIL reset_dut3 busy=%b ready=%b exp=0", bs1, rdy1); end
  endtask

  task automatic test_write;
    int lat, b; logic e; logic [31:0] q;
    issue(0, 0, 1, 32'h10, 32'hDEADBEEF, lat, e, q, b);
    checks++; if (lat !== 1) begin errors++; $display("FAIL write_latency got=%0d exp=1", lat); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL write_err got=%b exp=0", e); end
    checks++; if (b !== 1) begin errors++; $display("FAIL write_busy_cycles got=%0d exp=1", b); end
  endtask

  task automatic test_read_latency;
    int lat, b; logic e; logic [31:0] q;
    issue(0, 1, 0, 32'h10, 32'h0, lat, e, q, b);
    checks++; if (lat !== 2) begin errors++; $display("FAIL read_latency got=%0d exp=2", lat); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL read_err got=%b exp=0", e); end
    checks++; if (q !== 32'hDEADBEEF) begin errors++; $display("FAIL read_data got=%h exp=deadbeef", q); end
    checks++; if (b !== 2) begin errors++; $display("FAIL read_busy_cycles got=%0d exp=2", b); end
    repeat (3) @(negedge clk);
    checks++; if (rd0 !== 32'hDEADBEEF) begin errors++; $display("FAIL read_hold got=%h exp=deadbeef", rd0); end
    checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL read_single_pulse got=%b exp=0", rdy0); end
  endtask

  task automatic test_misaligned;
    int lat, b; logic e; logic [31:0] q;
    issue(0, 1, 0, 32'h13, 32'h0, lat, e, q, b);
    checks++; if (lat !== 1 || e !== 1'b1) begin errors++; $display("FAIL misaligned_read lat=%0d err=%b exp lat=1 err=1", lat, e); end
    checks++; if (q !== 32'hDEADBEEF) begin errors++; $display("FAIL misaligned_rdata got=%h exp=deadbeef", q); end
    issue(0, 0, 1, 32'h12, 32'h0BAD0BAD, lat, e, q, b);
    checks++; if (lat !== 1 || e !== 1'b1) begin errors++; $display("FAIL misaligned_write lat=%0d err=%b exp lat=1 err=1", lat, e); end
    issue(0, 1, 0, 32'h10, 32'h0, lat, e, q, b);
    checks++; if (q !== 32'hDEADBEEF || e !== 1'b0) begin errors++; $display("FAIL misaligned_ram got=%h err=%b exp=deadbeef err=0", q, e); end
  endtask

  task automatic test_range;
    int lat, b; logic e; logic [31:0] q;
    issue(0, 1, 0, 32'h00001000, 32'h0, lat, e, q, b);
    checks++; if (lat !== 1 || e !== 1'b1) begin errors++; $display("FAIL range_read lat=%0d err=%b exp lat=1 err=1", lat, e); end
    // 0x1010 would alias word 4 (0x10) if the upper bits were dropped.
    issue(0, 0, 1, 32'h00001010, 32'h55555555, lat, e, q, b);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL range_write err=%b exp=1", e); end
    issue(0, 1, 0, 32'h10, 32'h0, lat, e, q, b);
    checks++; if (q !== 32'hDEADBEEF) begin errors++; $display("FAIL range_alias got=%h exp=deadbeef", q); end
    // Highest valid word.
    issue(0, 0, 1, 32'h00000FFC, 32'h600DF00D, lat, e, q, b);
    checks++; if (e !== 1'b0 || lat !== 1) begin errors++; $display("FAIL top_word_write lat=%0d err=%b exp lat=1 err=0", lat, e); end
    issue(0, 1, 0, 32'h00000FFC, 32'h0, lat, e, q, b);
    checks++; if (q !== 32'h600DF00D || e !== 1'b0) begin errors++; $display("FAIL top_word_read got=%h err=%b exp=600df00d err=0", q, e); end
  endtask

  task automatic test_conflict;
    int lat, b; logic e; logic [31:0] q;
    issue(0, 0, 1, 32'h20, 32'hA5A5A5A5, lat, e, q, b);
    issue(0, 1, 1, 32'h20, 32'h11111111, lat, e, q, b);
    checks++; if (lat !== 1 || e !== 1'b1) begin errors++; $display("FAIL conflict lat=%0d err=%b exp lat=1 err=1", lat, e); end
    issue(0, 1, 0, 32'h20, 32'h0, lat, e, q, b);
    checks++; if (q !== 32'hA5A5A5A5) begin errors++; $display("FAIL conflict_ram got=%h exp=a5a5a5a5", q); end
  endtask

  task automatic test_held_strobe;
    logic [31:0] q;
    int          pulses;
    logic        prev;
    pulses = 0; prev = 1'b0;
    @(negedge clk);
    mr0 = 1'b1; ad0 = 32'h10;
    // Acceptance at the first edge, then every third edge: ready is seen at
    // negedges 2, 5, 8.
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      checks++;
      if (rdy0 !== (i % 3 == 2)) begin errors++; $display("FAIL held_ready cycle=%0d got=%b exp=%b", i, rdy0, (i % 3 == 2)); end
      if (rdy0 === 1'b1) begin
        pulses++;
        q = rd0;
        checks++; if (q !== 32'hDEADBEEF) begin errors++; $display("FAIL held_rdata cycle=%0d got=%h exp=deadbeef", i, q); end
      end
      if (prev === 1'b1 && rdy0 === 1'b1) begin errors++; $display("FAIL held_consecutive cycle=%0d", i); end
      prev = rdy0;
    end
    mr0 = 1'b0;
    checks++; if (pulses !== 3) begin errors++; $display("FAIL held_pulse_count got=%0d exp=3", pulses); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid_write;
    int lat, b; logic e; logic [31:0] q;
    int seen;
    issue(1, 0, 1, 32'h24, 32'hCAFEF00D, lat, e, q, b);
    checks++; if (lat !== 3 || e !== 1'b0) begin errors++; $display("FAIL lat3_write lat=%0d err=%b exp lat=3 err=0", lat, e); end
    @(negedge clk);
    mw1 = 1'b1; ad1 = 32'h24; wd1 = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    mw1 = 1'b0;
    checks++; if (bs1 !== 1'b1) begin errors++; $display("FAIL mid_write_busy got=%b exp=1", bs1); end
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rdy1 === 1'b1 || er1 === 1'b1) seen++;
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rdy1 === 1'b1 || er1 === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL mid_write_pulse got=%0d exp=0", seen); end
    checks++; if (rd1 !== 32'h0 || bs1 !== 1'b0) begin errors++; $display("FAIL mid_write_reset_state rdata=%h busy=%b exp 0", rd1, bs1); end
    issue(1, 1, 0, 32'h24, 32'h0, lat, e, q, b);
    checks++; if (q !== 32'hCAFEF00D || lat !== 2) begin errors++; $display("FAIL mid_write_ram got=%h lat=%0d exp=cafef00d lat=2", q, lat); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_latency();
    test_misaligned();
    test_range();
    test_conflict();
    test_held_strobe();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
